// File: rtl/video_fetch_arbiter.sv
// DRAM slot arbiter between the video fetch port and the CPU port.
// Each 4-clock slot is decided at ph==3; video wins the slots picked by video_bw.
module video_fetch_arbiter #(
   parameter int unsigned ADDR_W = 21,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   input  logic [ADDR_W-1:0] video_addr,
   input  logic [1:0]        video_bw,
   output logic              video_next,
   output logic              video_strobe,
   output logic [DATA_W-1:0] video_data,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_rnw,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_next,
   output logic              cpu_strobe,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              dram_req,
   output logic [ADDR_W-1:0] dram_addr,
   output logic              dram_rnw,
   output logic [DATA_W-1:0] dram_wdata,
   input  logic [DATA_W-1:0] dram_rdata
);

   typedef enum logic [1:0] {IDLE, VIDEO, CPU} owner_t;

   owner_t     owner, owner_nxt;
   logic [1:0] ph;
   logic [2:0] sc;
   logic       decide;
   logic       vsel;
   logic       capture;

   assign decide  = (ph == 2'd3);
   assign capture = (ph == 2'd2);

   always_comb begin
      case (video_bw)
         2'b11:   vsel = 1'b1;
         2'b10:   vsel = ~sc[0];
         2'b01:   vsel = (sc[1:0] == 2'b00);
         default: vsel = (sc == 3'd0);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) owner <= IDLE;
      else        owner <= owner_nxt;
   end

   always_comb begin
      owner_nxt = owner;
      if (decide) begin
         if (go && vsel)   owner_nxt = VIDEO;
         else if (cpu_req) owner_nxt = CPU;
         else              owner_nxt = IDLE;
      end
   end

   always_comb begin
      video_next = 1'b0;
      cpu_next   = 1'b0;
      if (decide) begin
         video_next = go & vsel;
         cpu_next   = cpu_req & ~(go & vsel);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph           <= '0;
         sc           <= '0;
         dram_req     <= 1'b0;
         dram_addr    <= '0;
         dram_rnw     <= 1'b1;
         dram_wdata   <= '0;
         video_strobe <= 1'b0;
         cpu_strobe   <= 1'b0;
         video_data   <= '0;
         cpu_rdata    <= '0;
      end else begin
         ph <= ph + 2'd1;
         // sc clears on any clock with go low, not only at decisions
         if (!go)         sc <= '0;
         else if (decide) sc <= sc + 3'd1;

         if (decide) begin
            dram_req   <= (owner_nxt != IDLE);
            dram_wdata <= cpu_wdata;
            if (owner_nxt == VIDEO) begin
               dram_addr <= video_addr;
               dram_rnw  <= 1'b1;
            end else if (owner_nxt == CPU) begin
               dram_addr <= cpu_addr;
               dram_rnw  <= cpu_rnw;
            end
         end

         video_strobe <= capture && (owner == VIDEO);
         cpu_strobe   <= capture && (owner == CPU);
         if (capture && owner == VIDEO)             video_data <= dram_rdata;
         if (capture && owner == CPU && dram_rnw)   cpu_rdata  <= dram_rdata;
      end
   end

endmodule

// File: tb/tb_video_fetch_arbiter.sv
// Bench for video_fetch_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_video_fetch_arbiter;
   localparam int unsigned ADDR_W = 21;
   localparam int unsigned DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              go = 1'b0;
   logic [ADDR_W-1:0] video_addr = '0;
   logic [1:0]        video_bw = 2'b00;
   logic              video_next, video_strobe;
   logic [DATA_W-1:0] video_data;
   logic              cpu_req = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic              cpu_rnw = 1'b1;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_next, cpu_strobe;
   logic [DATA_W-1:0] cpu_rdata;
   logic              dram_req, dram_rnw;
   logic [ADDR_W-1:0] dram_addr;
   logic [DATA_W-1:0] dram_wdata;
   logic [DATA_W-1:0] dram_rdata = '0;

   video_fetch_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .video_addr(video_addr), .video_bw(video_bw),
      .video_next(video_next), .video_strobe(video_strobe), .video_data(video_data),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw), .cpu_wdata(cpu_wdata),
      .cpu_next(cpu_next), .cpu_strobe(cpu_strobe), .cpu_rdata(cpu_rdata),
      .dram_req(dram_req), .dram_addr(dram_addr), .dram_rnw(dram_rnw),
      .dram_wdata(dram_wdata), .dram_rdata(dram_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // slot-level reference: which master owns the current slot and what it carries
   int                m_cyc, m_dec, m_kind;   // kind: 0 idle, 1 video, 2 cpu
   logic [ADDR_W-1:0] m_addr;
   logic              s_rnw;
   logic [DATA_W-1:0] s_wdata, m_vdata, m_crdata;
   bit                e_vnext, e_cnext, v_adv, c_acc;

   // stimulus controls, applied at the falling edge inside step()
   bit                nx_go;
   logic [1:0]        nx_bw;
   int                cpu_mode;  // 0 none, 1 always, 2 random, 3 explicit only
   bit                rd_rand;
   bit                p_load;
   logic [ADDR_W-1:0] p_addr;
   logic              p_rnw;
   logic [DATA_W-1:0] p_wdata;

   int n_vnext, n_cnext, n_vstb, n_cstb, n_dreq;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit video_slot(input int dec, input logic [1:0] bw);
      int period;
      period = 8 >> bw;
      return (dec % period) == 0;
   endfunction

   task automatic model_reset();
      m_cyc = 0; m_dec = 0; m_kind = 0; m_addr = '0; s_rnw = 1'b1; s_wdata = '0;
      m_vdata = '0; m_crdata = '0; v_adv = 1'b0; c_acc = 1'b0;
   endtask

   task automatic new_cpu();
      if (cpu_mode == 1 || (cpu_mode == 2 && $urandom_range(0, 1) == 1)) begin
         cpu_req   = 1'b1;
         cpu_addr  = ADDR_W'($urandom);
         cpu_rnw   = 1'($urandom);
         cpu_wdata = DATA_W'($urandom);
      end else begin
         cpu_req = 1'b0;
      end
   endtask

   task automatic clear_counts();
      n_vnext = 0; n_cnext = 0; n_vstb = 0; n_cstb = 0; n_dreq = 0;
   endtask

   task automatic step();
      int ph;
      @(negedge clk);
      go       = nx_go;
      video_bw = nx_bw;
      if (v_adv) video_addr = video_addr + 1'b1;
      v_adv = 1'b0;
      if (p_load) begin
         cpu_req = 1'b1; cpu_addr = p_addr; cpu_rnw = p_rnw; cpu_wdata = p_wdata; p_load = 1'b0;
         c_acc = 1'b0;
      end else if (c_acc) begin
         c_acc = 1'b0;
         new_cpu();
      end else if (!cpu_req && (cpu_mode == 1 || cpu_mode == 2)) begin
         new_cpu();
      end
      dram_rdata = rd_rand ? DATA_W'($urandom) : DATA_W'(16'hA000 + m_cyc / 4);
      #1;
      ph      = m_cyc % 4;
      e_vnext = (ph == 3) && go && video_slot(m_dec, video_bw);
      e_cnext = (ph == 3) && cpu_req && !e_vnext;

      chk("video_next",   32'(video_next),   32'(e_vnext));
      chk("cpu_next",     32'(cpu_next),     32'(e_cnext));
      chk("dram_req",     32'(dram_req),     32'(m_kind != 0));
      chk("dram_addr",    32'(dram_addr),    32'(m_addr));
      if (m_kind != 0) chk("dram_rnw", 32'(dram_rnw), 32'(s_rnw));
      if (m_kind == 2 && !s_rnw) chk("dram_wdata", 32'(dram_wdata), 32'(s_wdata));
      chk("video_strobe", 32'(video_strobe), 32'(ph == 3 && m_kind == 1));
      chk("cpu_strobe",   32'(cpu_strobe),   32'(ph == 3 && m_kind == 2));
      chk("video_data",   32'(video_data),   32'(m_vdata));
      chk("cpu_rdata",    32'(cpu_rdata),    32'(m_crdata));

      n_vnext += int'(video_next);
      n_cnext += int'(cpu_next);
      n_vstb  += int'(video_strobe);
      n_cstb  += int'(cpu_strobe);
      n_dreq  += int'(dram_req);

      if (ph == 2) begin
         if (m_kind == 1)           m_vdata  = dram_rdata;
         if (m_kind == 2 && s_rnw)  m_crdata = dram_rdata;
      end
      if (!go)           m_dec = 0;
      else if (ph == 3)  m_dec++;
      if (ph == 3) begin
         if (e_vnext) begin
            m_kind = 1; m_addr = video_addr; s_rnw = 1'b1; v_adv = 1'b1;
         end else if (e_cnext) begin
            m_kind = 2; m_addr = cpu_addr; s_rnw = cpu_rnw; s_wdata = cpu_wdata; c_acc = 1'b1;
         end else begin
            m_kind = 0;
         end
      end
      m_cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic align_slot();
      for (int i = 0; i < 4 && (m_cyc % 4) != 0; i++) step();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_dram_req",     32'(dram_req),     32'd0);
      chk("rst_dram_addr",    32'(dram_addr),    32'd0);
      chk("rst_dram_rnw",     32'(dram_rnw),     32'd1);
      chk("rst_dram_wdata",   32'(dram_wdata),   32'd0);
      chk("rst_video_strobe", 32'(video_strobe), 32'd0);
      chk("rst_cpu_strobe",   32'(cpu_strobe),   32'd0);
      chk("rst_video_data",   32'(video_data),   32'd0);
      chk("rst_cpu_rdata",    32'(cpu_rdata),    32'd0);
      chk("rst_video_next",   32'(video_next),   32'd0);
      chk("rst_cpu_next",     32'(cpu_next),     32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      nx_go = 1'b0; nx_bw = 2'b00; cpu_mode = 0; rd_rand = 1'b0; p_load = 1'b0;
      p_addr = '0; p_rnw = 1'b1; p_wdata = '0;
      model_reset();
      clear_counts();

      // reset and quiet idle
      do_reset();
      run(16);
      chk("idle_activity", 32'(n_vnext + n_cnext + n_vstb + n_cstb), 32'd0);
      chk("idle_dram_req", 32'(n_dreq), 32'd0);

      // full bandwidth with a CPU that is always asking
      nx_go = 1'b1; nx_bw = 2'b11; cpu_mode = 1;
      run(8);
      align_slot();
      clear_counts();
      run(32);
      chk("full_vnext", 32'(n_vnext), 32'd8);
      chk("full_cnext", 32'(n_cnext), 32'd0);
      chk("full_vstb",  32'(n_vstb),  32'd8);

      // sharing: one video slot in four
      nx_bw = 2'b01;
      run(16);
      align_slot();
      clear_counts();
      run(64);
      chk("share_vnext", 32'(n_vnext), 32'd4);
      chk("share_cnext", 32'(n_cnext), 32'd12);
      chk("share_cstb",  32'(n_cstb),  32'd12);

      // minimum bandwidth, CPU quiet
      cpu_mode = 0; nx_bw = 2'b00;
      run(32);
      align_slot();
      clear_counts();
      run(64);
      chk("min_vnext", 32'(n_vnext), 32'd2);
      chk("min_dreq",  32'(n_dreq),  32'd8);

      // single CPU write with video off
      nx_go = 1'b0; cpu_mode = 3;
      run(8);
      p_addr = 21'h12345; p_rnw = 1'b0; p_wdata = 16'hBEEF; p_load = 1'b1;
      clear_counts();
      run(16);
      chk("wr_cstb",  32'(n_cstb),  32'd1);
      chk("wr_cnext", 32'(n_cnext), 32'd1);

      // go falls in ph 1 of a video slot
      cpu_mode = 0; nx_go = 1'b1; nx_bw = 2'b11;
      run(8);
      for (int i = 0; i < 16 && !((m_cyc % 4) == 1 && m_kind == 1); i++) step();
      chk("drop_align", 32'((m_cyc % 4) == 1 && m_kind == 1), 32'd1);
      nx_go = 1'b0;
      clear_counts();
      run(12);
      chk("drop_vstb",  32'(n_vstb),  32'd1);
      chk("drop_vnext", 32'(n_vnext), 32'd0);
      nx_go = 1'b1; nx_bw = 2'b01;
      run(16);

      // reset pulse in ph 1 of a video slot
      nx_bw = 2'b11;
      for (int i = 0; i < 16 && !((m_cyc % 4) == 1 && m_kind == 1); i++) step();
      chk("rst_align", 32'((m_cyc % 4) == 1 && m_kind == 1), 32'd1);
      nx_go = 1'b0;
      do_reset();
      clear_counts();
      run(16);
      chk("rst_vstb", 32'(n_vstb), 32'd0);
      chk("rst_dreq", 32'(n_dreq), 32'd0);

      // random traffic
      rd_rand = 1'b1; cpu_mode = 2;
      for (int k = 0; k < 60; k++) begin
         nx_go = ($urandom_range(0, 4) != 0);
         nx_bw = 2'($urandom);
         run(int'($urandom_range(5, 20)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_fetch_arbiter.md
Name: video_fetch_arbiter

Overview:
DRAM-side responder for the video fetch port. It accepts video_addr and video_bw from the video address generator and returns video_next, video_strobe and video_data. Each 4-clock DRAM slot is granted to either video or the CPU: video has priority in slots selected by the bandwidth code, and the CPU gets the rest. The block sits between the video/CPU masters and the DRAM controller.

Parameters:
ADDR_W, 21, DRAM word address width
DATA_W, 16, DRAM data word width

Ports:
clk  in  1  28 MHz system clock
rst_n  in  1  asynchronous active-low reset
go  in  1  video fetch window active
video_addr  in  ADDR_W  video fetch address, advanced by the producer on video_next
video_bw  in  2  video bandwidth code
video_next  out  1  video address consumed this clock (combinational)
video_strobe  out  1  video_data valid (one clk pulse)
video_data  out  DATA_W  fetched video word
cpu_req  in  1  CPU access request, held until cpu_next
cpu_addr  in  ADDR_W  CPU address
cpu_rnw  in  1  1 = read, 0 = write
cpu_wdata  in  DATA_W  CPU write data
cpu_next  out  1  CPU request accepted (combinational)
cpu_strobe  out  1  CPU access complete; cpu_rdata valid if read
cpu_rdata  out  DATA_W  CPU read data
dram_req  out  1  DRAM cycle active
dram_addr  out  ADDR_W  DRAM address
dram_rnw  out  1  DRAM direction
dram_wdata  out  DATA_W  DRAM write data
dram_rdata  in  DATA_W  DRAM read data, valid in phase 2 of the slot

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: ph=0, sc=0, owner=IDLE, dram_req=0, dram_addr=0, dram_rnw=1, dram_wdata=0, video_strobe=0, cpu_strobe=0, video_data=0, cpu_rdata=0.
- Phase counter ph[1:0]: free-running 0,1,2,3,0... A slot is ph 0..3. The clock with ph==3 is the decision clock for the next slot.
- Slot counter sc[2:0]:
  - Held at 0 while go=0.
  - While go=1, increments at each decision clock and wraps 7->0.
  - The first decision after go rises therefore sees sc=0.
- Video slot select vsel, by video_bw:
  - 11: all slots
  - 10: sc[0]==0
  - 01: sc[1:0]==0
  - 00: sc==0
- Decision at ph==3:
  - video_next = go & vsel.
  - cpu_next = cpu_req & ~video_next.
  - Both are zero at every other phase. Both are combinational, so the producer advances its address on the same edge this block latches it.
- On the edge ending the decision clock:
  - owner <= VIDEO, CPU or IDLE.
  - dram_addr <= the winning address.
  - dram_rnw <= 1 for VIDEO, cpu_rnw for CPU.
  - dram_wdata <= cpu_wdata.
  - dram_req <= (owner != IDLE), held for ph 0..3 of the slot.
  - go, video_bw and cpu_req are sampled only at ph==3.
- Read capture: on the edge ending ph==2 of an owned read slot, dram_rdata is loaded into video_data (VIDEO) or cpu_rdata (CPU read).
- Strobes:
  - video_strobe is registered high during ph==3 of a VIDEO slot.
  - cpu_strobe is high during ph==3 of a CPU slot, read or write.
  - Latency: next at clock T gives strobe at T+4. The strobe coincides with the next decision clock.
- Data registers hold their value between strobes.
- Simultaneous events: video and CPU contend at one decision -> video wins, cpu_req stays pending, CPU is not acknowledged.
- go falls mid-slot: the current slot completes and its strobe is still issued. sc clears on the next clock.
- video_bw changes mid-slot: takes effect at the next decision only.
- IDLE slot: dram_req=0, no strobes, dram_addr holds.
- rst_n asserted mid-slot: immediate return to reset values. An in-flight access produces no strobe. After release, ph restarts at 0 and the first decision is at the 4th clock.

Test Plan:
- Reset: rst_n low then high, go=0, cpu_req=0 -> all outputs at reset values; dram_req stays 0; no next or strobe for 16 clocks.
- Full bandwidth: go=1, video_bw=11, dram_rdata = 16'hA000+slot index -> video_next every 4 clocks at ph==3; video_strobe 4 clocks after each next; video_data = A000, A001, ... in order; cpu_next never asserted.
- Sharing: go=1, video_bw=01, cpu_req held high -> slot owners repeat V,C,C,C; cpu_next and cpu_strobe pulse 3 times per 4 slots.
- Minimum bandwidth: go=1, video_bw=00, cpu_req=0 -> exactly 1 video_next per 32 clocks; dram_req low in 7 of every 8 slots.
- CPU write: cpu_req=1, cpu_rnw=0, cpu_addr=21'h12345, cpu_wdata=16'hBEEF, go=0 -> dram_addr=12345, dram_rnw=0, dram_wdata=BEEF for one slot; cpu_strobe at ph==3; cpu_rdata unchanged.
- Go drop and mid-slot reset: go falls during ph==1 of a video slot -> strobe still issued and sc=0 afterwards; separately, rst_n pulsed low at ph==1 -> no strobe, outputs at reset values immediately.
